// File: rtl/sipo_byte_rx.sv
// sipo_byte_rx: serial-in/parallel-out word assembler with a one-word output slot and overrun flag
module sipo_byte_rx #(
  parameter int WIDTH = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             byte_ack,
  output logic [WIDTH-1:0] data_out,
  output logic             byte_valid,
  output logic             overrun,
  output logic [CW-1:0]    bit_count
);
  typedef enum logic {IDLE, RECV} state_t;
  state_t state, state_d;
  logic [WIDTH-1:0] shreg, shifted, sh_d;
  logic [CW-1:0] cnt_d;
  logic accept, last, take;
  // next receive state; the final bit of a word is folded into the word it completes
  always_comb begin
    accept = en & bit_valid;
    shifted = MSB_FIRST ? {shreg[WIDTH-2:0], bit_in} : {bit_in, shreg[WIDTH-1:1]};
    last = accept && state == RECV && bit_count == CW'(WIDTH - 1);
    state_d = !accept ? state : last ? IDLE : RECV;
    cnt_d = !accept ? bit_count : last ? '0 : bit_count + CW'(1);
    sh_d = accept ? shifted : shreg;
    take = last & (~byte_valid | byte_ack);
  end
  // receive registers and output slot; a completed word wins over a same-cycle ack
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      bit_count <= '0;
      data_out <= '0;
      byte_valid <= 1'b0;
      overrun <= 1'b0;
    end else if (clear) begin
      state <= IDLE;
      shreg <= '0;
      bit_count <= '0;
      overrun <= 1'b0;
      byte_valid <= byte_valid & ~byte_ack;
    end else begin
      state <= state_d;
      shreg <= sh_d;
      bit_count <= cnt_d;
      if (take) begin
        data_out <= shifted;
        byte_valid <= 1'b1;
      end else if (last) overrun <= 1'b1;
      else if (byte_ack) byte_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sipo_byte_rx.sv
// tb_sipo_byte_rx: directed and random checks of both bit orders against a word-level model
module tb_sipo_byte_rx;
  localparam int W = 8;
  logic clk = 1'b0;
  logic reset, en, clear, bit_in, bit_valid, byte_ack;
  logic [W-1:0] data_m, data_l;
  logic valid_m, valid_l, ovr_m, ovr_l;
  logic [3:0] cnt_m, cnt_l;
  int checks = 0;
  int errors = 0;
  int nb;
  logic bits [W];
  logic [W-1:0] e_data_m, e_data_l;
  logic e_valid_m, e_valid_l, e_ovr_m, e_ovr_l;

  always #5 clk = ~clk;

  sipo_byte_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .en(en), .clear(clear), .bit_in(bit_in),
    .bit_valid(bit_valid), .byte_ack(byte_ack), .data_out(data_m),
    .byte_valid(valid_m), .overrun(ovr_m), .bit_count(cnt_m));

  sipo_byte_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .en(en), .clear(clear), .bit_in(bit_in),
    .bit_valid(bit_valid), .byte_ack(byte_ack), .data_out(data_l),
    .byte_valid(valid_l), .overrun(ovr_l), .bit_count(cnt_l));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic slot(input logic done, input logic [W-1:0] word,
                      inout logic [W-1:0] d, inout logic v, inout logic o);
    if (done) begin
      if (!v || byte_ack) begin
        d = word;
        v = 1'b1;
      end else o = 1'b1;
    end else if (byte_ack) v = 1'b0;
  endtask

  task automatic model_edge();
    logic done;
    logic [W-1:0] wm, wl;
    done = 1'b0;
    wm = '0;
    wl = '0;
    if (reset) begin
      nb = 0;
      {e_data_m, e_data_l, e_valid_m, e_valid_l, e_ovr_m, e_ovr_l} = '0;
    end else if (clear) begin
      nb = 0;
      e_ovr_m = 1'b0;
      e_ovr_l = 1'b0;
      if (byte_ack) begin
        e_valid_m = 1'b0;
        e_valid_l = 1'b0;
      end
    end else begin
      if (en && bit_valid) begin
        bits[nb] = bit_in;
        nb++;
        if (nb == W) begin
          done = 1'b1;
          nb = 0;
          for (int i = 0; i < W; i++) begin
            wm = wm + (W'(bits[i]) << (W - 1 - i));
            wl = wl + (W'(bits[i]) << i);
          end
        end
      end
      slot(done, wm, e_data_m, e_valid_m, e_ovr_m);
      slot(done, wl, e_data_l, e_valid_l, e_ovr_l);
    end
  endtask

  task automatic step(input logic e, input logic bv, input logic b,
                      input logic a, input logic c, input logic r);
    en = e; bit_valid = bv; bit_in = b; byte_ack = a; clear = c; reset = r;
    @(posedge clk);
    model_edge();
    #1;
    chk("data_msb", data_m, e_data_m);
    chk("valid_msb", valid_m, e_valid_m);
    chk("ovr_msb", ovr_m, e_ovr_m);
    chk("cnt_msb", cnt_m, nb);
    chk("data_lsb", data_l, e_data_l);
    chk("valid_lsb", valid_l, e_valid_l);
    chk("ovr_lsb", ovr_l, e_ovr_l);
    chk("cnt_lsb", cnt_l, nb);
  endtask

  task automatic send(input logic [W-1:0] w, input logic ack_last);
    for (int i = 0; i < W; i++) step(1'b1, 1'b1, w[W-1-i], ack_last && i == W - 1, 1'b0, 1'b0);
  endtask

  initial begin
    nb = 0;
    {e_data_m, e_data_l, e_valid_m, e_valid_l, e_ovr_m, e_ovr_l} = '0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("reset_data", data_m, 8'h00);
    chk("reset_valid", valid_m, 1'b0);
    // msb-first 0x81 with bit_count progression
    for (int i = 0; i < W; i++) begin
      step(1'b1, 1'b1, (i == 0 || i == 7), 1'b0, 1'b0, 1'b0);
      chk("t1_cnt", cnt_m, (i + 1) % W);
    end
    chk("t1_data", data_m, 8'h81);
    chk("t1_valid", valid_m, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t1_ack", valid_m, 1'b0);
    // lsb-first 1,1,0,0,0,0,0,0
    send(8'hC0, 1'b0);
    chk("t2_lsb", data_l, 8'h03);
    chk("t2_msb", data_m, 8'hC0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    // gaps: en=0 with offered bits, and bit_valid=0
    for (int i = 0; i < W; i++) begin
      step(1'b1, 1'b1, (i == 0 || i == 7), 1'b0, 1'b0, 1'b0);
      if (i < W - 1) begin
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t3_frozen_en", cnt_m, i + 1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t3_frozen_bv", cnt_m, i + 1);
      end
    end
    chk("t3_data", data_m, 8'h81);
    // overrun while 0x81 pending
    send(8'h3C, 1'b0);
    chk("t4_kept", data_m, 8'h81);
    chk("t4_ovr", ovr_m, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t4_ack", valid_m, 1'b0);
    chk("t4_ovr_sticky", ovr_m, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t4_clear", ovr_m, 1'b0);
    // ack coincident with completion
    send(8'h81, 1'b0);
    send(8'hA5, 1'b1);
    chk("t5_data", data_m, 8'hA5);
    chk("t5_valid", valid_m, 1'b1);
    chk("t5_ovr", ovr_m, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    // reset mid-word
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t6_rst_cnt", cnt_m, 0);
    chk("t6_rst_data", data_m, 8'h00);
    send(8'hF0, 1'b0);
    chk("t6_data", data_m, 8'hF0);
    // clear mid-word keeps pending word
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t6_clr_cnt", cnt_m, 0);
    chk("t6_clr_data", data_m, 8'hF0);
    chk("t6_clr_valid", valid_m, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send(8'h5A, 1'b0);
    chk("t6_after_clr", data_m, 8'h5A);
    // random traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, 1'($urandom),
           $urandom_range(0, 9) < 2, $urandom_range(0, 99) == 0, $urandom_range(0, 199) == 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
